// File: rtl/riscv_imm_pack.sv
// rtl/riscv_imm_pack.sv - RV32I immediate-format instruction packer with LI expansion
// Optional range checking on instr_err_o: define RISCV_IMM_PACK_RANGE_CHK_EN.
module riscv_imm_pack #(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            arst_n_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [3:0]      req_op_i,
    input  logic [2:0]      req_funct3_i,
    input  logic [4:0]      req_rd_i,
    input  logic [4:0]      req_rs1_i,
    input  logic [4:0]      req_rs2_i,
    input  logic [XLEN-1:0] req_imm_i,
    output logic            instr_valid_o,
    input  logic            instr_ready_i,
    output logic [XLEN-1:0] instr_o,
    output logic            instr_err_o
);

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;

    logic        valid_q, valid_d;
    logic        err_q, err_d;
    logic        pend_q, pend_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pend_word_q, pend_word_d;

    logic [31:0] word_a;
    logic [31:0] word_b;
    logic        two_word;
    logic        err_c;
    logic        fits_i12;
    logic [31:0] li_hi;
    logic [31:0] imm;

    assign imm      = req_imm_i;
    assign fits_i12 = (&imm[31:11]) | ~(|imm[31:11]);
    // Low half of a split LI is sign-extended by ADDI, so the upper half is pre-rounded.
    assign li_hi    = imm + 32'h0000_0800;

    always_comb begin
        word_a   = NOP_WORD;
        word_b   = NOP_WORD;
        two_word = 1'b0;
        case (req_op_i)
            4'd0: word_a = {imm[11:0], req_rs1_i, req_funct3_i, req_rd_i, OPC_OPIMM};
            4'd1: word_a = {imm[11:0], req_rs1_i, req_funct3_i, req_rd_i, OPC_LOAD};
            4'd2: word_a = {imm[11:5], req_rs2_i, req_rs1_i, req_funct3_i, imm[4:0], OPC_STORE};
            4'd3: word_a = {imm[12], imm[10:5], req_rs2_i, req_rs1_i, req_funct3_i,
                            imm[4:1], imm[11], OPC_BRANCH};
            4'd4: word_a = {imm[31:12], req_rd_i, OPC_LUI};
            4'd5: word_a = {imm[31:12], req_rd_i, OPC_AUIPC};
            4'd6: word_a = {imm[20], imm[10:1], imm[11], imm[19:12], req_rd_i, OPC_JAL};
            4'd7: word_a = {imm[11:0], req_rs1_i, req_funct3_i, req_rd_i, OPC_JALR};
            4'd8: begin
                if (fits_i12) begin
                    word_a = {imm[11:0], 5'd0, 3'b000, req_rd_i, OPC_OPIMM};
                end else if (imm[11:0] == 12'd0) begin
                    word_a = {imm[31:12], req_rd_i, OPC_LUI};
                end else begin
                    word_a   = {li_hi[31:12], req_rd_i, OPC_LUI};
                    word_b   = {imm[11:0], req_rd_i, 3'b000, req_rd_i, OPC_OPIMM};
                    two_word = 1'b1;
                end
            end
            default: word_a = NOP_WORD;
        endcase
    end

`ifdef RISCV_IMM_PACK_RANGE_CHK_EN
    logic fits_b13;
    logic fits_j21;

    assign fits_b13 = (&imm[31:12]) | ~(|imm[31:12]);
    assign fits_j21 = (&imm[31:20]) | ~(|imm[31:20]);

    always_comb begin
        err_c = 1'b0;
        case (req_op_i)
            4'd0, 4'd1, 4'd2, 4'd7: err_c = ~fits_i12;
            4'd3:                   err_c = ~fits_b13 | imm[0];
            4'd4, 4'd5:             err_c = |imm[11:0];
            4'd6:                   err_c = ~fits_j21 | imm[0];
            4'd8:                   err_c = 1'b0;
            default:                err_c = 1'b1;
        endcase
    end
`else
    assign err_c = 1'b0;
`endif

    assign req_ready_o = ~pend_q & (~valid_q | instr_ready_i);

    always_comb begin
        valid_d     = valid_q;
        err_d       = err_q;
        pend_d      = pend_q;
        instr_d     = instr_q;
        pend_word_d = pend_word_q;
        if (req_valid_i && req_ready_o) begin
            valid_d     = 1'b1;
            instr_d     = word_a;
            err_d       = err_c;
            pend_d      = two_word;
            pend_word_d = word_b;
        end else if (valid_q && instr_ready_i) begin
            // The captured ADDI follows the LUI handshake directly, without a bubble.
            if (pend_q) begin
                instr_d = pend_word_q;
                err_d   = 1'b0;
                pend_d  = 1'b0;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            valid_q     <= 1'b0;
            err_q       <= 1'b0;
            pend_q      <= 1'b0;
            instr_q     <= 32'd0;
            pend_word_q <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            err_q       <= err_d;
            pend_q      <= pend_d;
            instr_q     <= instr_d;
            pend_word_q <= pend_word_d;
        end
    end

    assign instr_valid_o = valid_q;
    assign instr_o       = instr_q;
    assign instr_err_o   = err_q;

endmodule

// File: tb/tb_riscv_imm_pack.sv
// tb/tb_riscv_imm_pack.sv - self-checking bench for riscv_imm_pack with an encoding model
module tb_riscv_imm_pack;

    logic        clk_i = 1'b0;
    logic        arst_n_i = 1'b0;
    logic        req_valid_i = 1'b0;
    logic        req_ready_o;
    logic [3:0]  req_op_i = 4'd0;
    logic [2:0]  req_funct3_i = 3'd0;
    logic [4:0]  req_rd_i = 5'd0;
    logic [4:0]  req_rs1_i = 5'd0;
    logic [4:0]  req_rs2_i = 5'd0;
    logic [31:0] req_imm_i = 32'd0;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b1;
    logic [31:0] instr_o;
    logic        instr_err_o;

    int n_cmp = 0;
    int n_bad = 0;
    logic [32:0] exp_q[$];

    riscv_imm_pack #(.XLEN(32)) dut (
        .clk_i(clk_i), .arst_n_i(arst_n_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_op_i(req_op_i), .req_funct3_i(req_funct3_i), .req_rd_i(req_rd_i),
        .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_imm_i(req_imm_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .instr_o(instr_o), .instr_err_o(instr_err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ity(input logic [31:0] im, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input int opc);
        return (({20'd0, im[11:0]}) << 20) | ({27'd0, rs1} << 15) | ({29'd0, f3} << 12)
               | ({27'd0, rd} << 7) | opc;
    endfunction

    function automatic logic [31:0] uty(input logic [31:0] im, input logic [4:0] rd, input int opc);
        return (im & 32'hFFFF_F000) | ({27'd0, rd} << 7) | opc;
    endfunction

    // Spec-level model: returns the ordered list of {err, word} the request must produce.
    task automatic model(input int op, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] im);
        int s;
        logic [31:0] w;
        logic [31:0] hi;
        logic e;
        s = $signed(im);
        e = 1'b0;
        w = 32'h13;
        case (op)
            0, 1, 7: begin
                w = ity(im, rs1, f3, rd, op == 0 ? 'h13 : (op == 1 ? 'h03 : 'h67));
                e = (s < -2048) || (s > 2047);
            end
            2: begin
                w = ((im >> 5) & 32'h7F) << 25 | {27'd0, rs2} << 20 | {27'd0, rs1} << 15
                    | {29'd0, f3} << 12 | (im & 32'h1F) << 7 | 32'h23;
                e = (s < -2048) || (s > 2047);
            end
            3: begin
                w = ((im >> 12) & 1) << 31 | ((im >> 5) & 32'h3F) << 25 | {27'd0, rs2} << 20
                    | {27'd0, rs1} << 15 | {29'd0, f3} << 12 | ((im >> 1) & 32'hF) << 8
                    | ((im >> 11) & 1) << 7 | 32'h63;
                e = (s < -4096) || (s > 4094) || im[0];
            end
            4, 5: begin
                w = uty(im, rd, op == 4 ? 'h37 : 'h17);
                e = (im & 32'hFFF) != 0;
            end
            6: begin
                w = ((im >> 20) & 1) << 31 | ((im >> 1) & 32'h3FF) << 21 | ((im >> 11) & 1) << 20
                    | ((im >> 12) & 32'hFF) << 12 | {27'd0, rd} << 7 | 32'h6F;
                e = (s < -(1 << 20)) || (s > (1 << 20) - 2) || im[0];
            end
            8: begin
                if (s >= -2048 && s <= 2047) begin
                    w = ity(im, 5'd0, 3'd0, rd, 'h13);
                end else if ((im & 32'hFFF) == 0) begin
                    w = uty(im, rd, 'h37);
                end else begin
                    hi = im + 32'h800;
                    exp_q.push_back({1'b0, uty(hi, rd, 'h37)});
                    w = ity(im, rd, 3'd0, rd, 'h13);
                end
            end
            default: e = 1'b1;
        endcase
`ifndef RISCV_IMM_PACK_RANGE_CHK_EN
        e = 1'b0;
`endif
        exp_q.push_back({e, w});
    endtask

    // Per-cycle compare of every presented word against the model queue head.
    always @(negedge clk_i) begin
        if (arst_n_i && instr_valid_o) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_word: got 0x%08h want none", instr_o);
            end else begin
                check("model_word", instr_o, exp_q[0][31:0]);
                check("model_err", {31'd0, instr_err_o}, {31'd0, exp_q[0][32]});
                if (instr_ready_i) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input int op, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] im,
                        output int waited);
        req_op_i = op[3:0]; req_funct3_i = f3; req_rd_i = rd;
        req_rs1_i = rs1; req_rs2_i = rs2; req_imm_i = im;
        req_valid_i = 1'b1;
        waited = 0;
        @(negedge clk_i);
        while (!req_ready_o && waited < 100) begin
            waited++;
            @(negedge clk_i);
        end
        if (waited >= 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: got ready=0 want ready=1");
        end
        @(posedge clk_i);
        model(op, f3, rd, rs1, rs2, im);
        #1 req_valid_i = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 50) begin
            @(negedge clk_i);
            k++;
        end
        @(posedge clk_i);
        #1;
    endtask

    int w;

    initial begin
        #2;
        check("reset_valid", {31'd0, instr_valid_o}, 32'd0);
        check("reset_instr", instr_o, 32'd0);
        check("reset_err", {31'd0, instr_err_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 arst_n_i = 1'b1;
        @(negedge clk_i);
        check("ready_after_reset", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk_i); #1;

        send(0, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, w);
        @(negedge clk_i);
        check("opimm_lat_valid", {31'd0, instr_valid_o}, 32'd1);
        check("opimm_word", instr_o, 32'hFFF0_0293);
        drain();

        send(8, 3'd7, 5'd10, 5'd3, 5'd4, 32'h1234_5FFF, w);
        @(negedge clk_i);
        check("li_first", instr_o, 32'h1234_6537);
        check("li_pend_ready", {31'd0, req_ready_o}, 32'd0);
        @(negedge clk_i);
        check("li_second", instr_o, 32'hFFF5_0513);
        check("li_second_valid", {31'd0, instr_valid_o}, 32'd1);
        drain();

        send(8, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_1000, w);
        @(negedge clk_i);
        check("li_lui_only", instr_o, 32'h0000_10B7);
        drain();
        send(3, 3'd0, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, w);
        @(negedge clk_i);
        check("branch_m4", instr_o, 32'hFE20_8EE3);
        drain();
        send(6, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0800, w);
        @(negedge clk_i);
        check("jal_800", instr_o, 32'h0010_00EF);
        drain();

        // Back-to-back mixed stream checked by the model alone.
        send(1, 3'd2, 5'd7, 5'd8, 5'd0, 32'hFFFF_F800, w);
        send(2, 3'd2, 5'd0, 5'd9, 5'd11, 32'h0000_07FF, w);
        send(7, 3'd0, 5'd1, 5'd2, 5'd0, 32'h0000_0010, w);
        send(5, 3'd0, 5'd3, 5'd0, 5'd0, 32'hABCD_E000, w);
        send(8, 3'd0, 5'd4, 5'd0, 5'd0, 32'hFFFF_F801, w);
        send(8, 3'd0, 5'd6, 5'd0, 5'd0, 32'h8000_0000, w);
        send(8, 3'd0, 5'd12, 5'd0, 5'd0, 32'h7FFF_FFFF, w);
        send(6, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFF0_0000, w);
        send(4, 3'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5678, w);
        drain();

        send(0, 3'd0, 5'd0, 5'd0, 5'd0, 32'd2048, w);
        @(negedge clk_i);
        check("opimm_2048_word", instr_o, 32'h8000_0013);
`ifdef RISCV_IMM_PACK_RANGE_CHK_EN
        check("opimm_2048_err", {31'd0, instr_err_o}, 32'd1);
`else
        check("opimm_2048_err", {31'd0, instr_err_o}, 32'd0);
`endif
        drain();
        send(3, 3'd0, 5'd0, 5'd1, 5'd2, 32'd3, w);
        send(12, 3'd0, 5'd3, 5'd4, 5'd5, 32'h1234, w);
        @(negedge clk_i);
        check("illegal_nop", instr_o, 32'h0000_0013);
        drain();

        instr_ready_i = 1'b0;
        send(8, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, w);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("bp_hold_word", instr_o, 32'h1234_6537);
            check("bp_ready_low", {31'd0, req_ready_o}, 32'd0);
        end
        @(posedge clk_i); #1 instr_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp_first_out", instr_o, 32'h1234_6537);
        @(negedge clk_i);
        check("bp_second_out", instr_o, 32'hFFF5_0513);
        drain();

        instr_ready_i = 1'b0;
        send(8, 3'd0, 5'd10, 5'd0, 5'd0, 32'h1234_5FFF, w);
        @(negedge clk_i);
        arst_n_i = 1'b0;
        #1;
        check("rst_async_valid", {31'd0, instr_valid_o}, 32'd0);
        exp_q.delete();
        instr_ready_i = 1'b1;
        @(negedge clk_i);
        arst_n_i = 1'b1;
        repeat (3) begin
            @(negedge clk_i);
            check("rst_no_addi", {31'd0, instr_valid_o}, 32'd0);
        end
        @(posedge clk_i); #1;
        send(0, 3'd0, 5'd5, 5'd0, 5'd0, 32'hFFFF_FFFF, w);
        check("rst_accept_now", w, 32'd0);
        @(negedge clk_i);
        check("rst_next_word", instr_o, 32'hFFF0_0293);
        drain();
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_left: got %0d want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_imm_pack.md
Name: riscv_imm_pack

Overview:
Instruction word builder for RV32I immediate-bearing formats. It packs an operation kind, register fields and a 32-bit immediate into a legal 32-bit instruction, which is the inverse of the core's immediate extraction. It expands the LI pseudo-op into one or two words (ADDI, LUI, or LUI+ADDI). It sits between a trap/patch/self-test sequencer and the instruction memory write port or the core fetch-inject path, with valid/ready on both sides.

Parameters:
XLEN, 32, data width; only 32 is supported.

Ports:
clk_i  in  1  clock, rising edge
arst_n_i  in  1  reset, asynchronous, active-low
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_op_i  in  4  0 OPIMM, 1 LOAD, 2 STORE, 3 BRANCH, 4 LUI, 5 AUIPC, 6 JAL, 7 JALR, 8 LI; 9-15 illegal
req_funct3_i  in  3  funct3; ignored for LUI/AUIPC/JAL/LI
req_rd_i  in  5  destination register
req_rs1_i  in  5  source 1
req_rs2_i  in  5  source 2 (STORE/BRANCH only)
req_imm_i  in  XLEN  immediate as a byte value (U-type: full value, imm[31:12] used)
instr_valid_o  out  1  output word valid
instr_ready_i  in  1  downstream ready
instr_o  out  XLEN  packed instruction
instr_err_o  out  1  immediate out of range or illegal op (qualified by instr_valid_o)

Behaviour:
- Reset: asynchronous, active-low. While arst_n_i=0: instr_valid_o=0, instr_o=0, instr_err_o=0, pending flag=0. req_ready_o=1 after release.
- Output is a single registered stage. Latency is 1 cycle from request accept to instr_valid_o.
- req_ready_o = !pend && (!instr_valid_o || instr_ready_i). This gives full throughput of single-word ops under constant ready.
- instr_o and instr_err_o hold stable while instr_valid_o=1 and instr_ready_i=0.
- Opcodes: OPIMM 0010011, LOAD 0000011, STORE 0100011, BRANCH 1100011, LUI 0110111, AUIPC 0010111, JAL 1101111, JALR 1100111.
- I (OPIMM/LOAD/JALR): [31:20]=imm[11:0], [19:15]=rs1, [14:12]=f3, [11:7]=rd.
- S: [31:25]=imm[11:5], [11:7]=imm[4:0], rs2 at [24:20].
- B: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- U: [31:12]=imm[31:12].
- J: [31]=imm[20], [30:21]=imm[10:1], [20]=imm[11], [19:12]=imm[19:12].
- LI rd, imm: rs1/f3/rs2 are ignored.
  - If imm fits signed 12 bits: one word, ADDI rd, x0, imm.
  - Else if imm[11:0]==0: one word, LUI rd, imm[31:12].
  - Else: LUI rd, (imm+0x800)[31:12], then ADDI rd, rd, imm[11:0]. The add is 32-bit modulo.
- Two-word LI: the first word is loaded and pend=1 with the ADDI word captured internally. On the first word's handshake, the ADDI word loads the next cycle and pend clears. No bubble is allowed under constant ready.
- Illegal op (9-15): emits NOP 0x00000013.
- Reset mid-operation (pending or stalled word): the word is dropped and pend is cleared. No partial LI resumes.

Optional Feature:
Macro: RISCV_IMM_PACK_RANGE_CHK_EN.
- Defined: instr_err_o=1 with the word (word still emitted, immediate truncated) for any of:
  - I/S immediate outside [-2048, 2047].
  - B immediate outside [-4096, 4094] or imm[0]=1.
  - J immediate outside [-2^20, 2^20-2] or imm[0]=1.
  - U immediate with imm[11:0]!=0.
  - Illegal op.
  - LI never errors.
- Undefined: instr_err_o is tied 0 and no check logic is built.

Test Plan:
- OPIMM f3=0, rd=5, rs1=0, imm=0xFFFFFFFF -> one word 0xFFF00293 one cycle after accept, err=0.
- LI rd=10, imm=0x12345FFF, instr_ready_i=1 -> 0x12346537 then 0xFFF50513 on consecutive cycles; req_ready_o=0 during pend.
- LI rd=1, imm=0x00001000 -> single word 0x000010B7. BRANCH f3=0, rs1=1, rs2=2, imm=-4 -> 0xFE208EE3. JAL rd=1, imm=0x800 -> 0x001000EF.
- Backpressure: hold instr_ready_i=0 for 5 cycles after a two-word LI -> first word stable, no second word, req_ready_o=0; releasing ready completes the sequence in order.
- With RISCV_IMM_PACK_RANGE_CHK_EN: OPIMM imm=2048 -> 0x80000013, err=1. BRANCH imm=3 -> err=1. Op 12 -> 0x00000013, err=1. Without the macro, err stays 0.
- Assert arst_n_i between LI words -> instr_valid_o drops asynchronously; after release no ADDI word appears and the next request is accepted immediately.
